// File: rtl/csa_resolve_adder.sv
// rtl/csa_resolve_adder.sv - iterative carry-propagate resolver for a CSA sum/carry pair
module csa_resolve_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH+2:0] sum_in,
    input  logic [WIDTH+2:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+3:0] result_out,
    output logic             ovf_out,
    output logic             busy_out
);

    localparam int RES_W  = WIDTH + 4;
    localparam int NCHUNK = (RES_W + CHUNK - 1) / CHUNK;
    // The last chunk may be narrower than CHUNK; its carry-out sits at bit LAST_W of the chunk sum.
    localparam int LAST_W = RES_W - (NCHUNK - 1) * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RES_W-1:0]   a_q, a_d;
    logic [RES_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    int                 base;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK:0]     chunk_sum;
    logic               chunk_cout;
    logic [RES_W-1:0]   slice_mask;
    logic [RES_W-1:0]   slice_sum;

    // One chunk of the ripple add: select the current slice, add with the stored carry,
    // and position the partial sum back at the slice offset. Zero-fill from the shift
    // keeps bits above RES_W-1 out of a short final chunk.
    always_comb begin
        base       = int'(idx_q) * CHUNK;
        chunk_a    = CHUNK'(a_q >> base);
        chunk_b    = CHUNK'(b_q >> base);
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        chunk_cout = (idx_q == LAST_IDX) ? chunk_sum[LAST_W] : chunk_sum[CHUNK];
        slice_mask = ({RES_W{1'b1}} >> (RES_W - CHUNK)) << base;
        slice_sum  = RES_W'(chunk_sum[CHUNK-1:0]) << base;
    end

    // Next-state and datapath control: capture in IDLE, resolve chunk by chunk in BUSY,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = {1'b0, sum_in};
                    b_d     = {carry_in, 1'b0};
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_d   = (res_q & ~slice_mask) | (slice_sum & slice_mask);
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = chunk_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy_out   = (state_q == ST_BUSY);
    assign out_valid  = (state_q == ST_DONE);
    assign result_out = res_q;
    assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb/tb_csa_resolve_adder.sv - scoreboard bench for csa_resolve_adder across CHUNK settings
module tb_csa_resolve_adder;

    localparam int WIDTH = 8;
    localparam int RES_W = WIDTH + 4;
    localparam int NCFG  = 4;
    localparam int NRAND = 1000;

    typedef struct packed {
        logic [1:0]     inst;
        logic [RES_W:0] exp;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0]  rstn, iv, ordy;
    logic [NCFG-1:0]  ir, ov, busy, ovf;
    logic [WIDTH+2:0] s_in [NCFG];
    logic [WIDTH+2:0] c_in [NCFG];
    logic [RES_W-1:0] res  [NCFG];

    // Instance 0 is CHUNK=4 for directed tests; 1..3 are CHUNK 1, 5, 12 for the sweep.
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 12;
        csa_resolve_adder #(.WIDTH(WIDTH), .CHUNK(CH)) u_dut (
            .clk        (clk),
            .rst_n      (rstn[g]),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .sum_in     (s_in[g]),
            .carry_in   (c_in[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .result_out (res[g]),
            .ovf_out    (ovf[g]),
            .busy_out   (busy[g])
        );
    end

    int              n_vec;
    int              n_err;
    int              cyc;
    int              acc_edge [NCFG];
    logic [NCFG-1:0] ov_prev;
    logic [NCFG-1:0] acc_seen;
    logic            rand_ordy;
    sb_t             sb [$];

    function automatic int lat_of(input int g);
        case (g)
            0:       return 3;
            1:       return 12;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: monitor at the falling edge, then advance past the rising edge.
    task automatic step();
        sb_t            e;
        logic [RES_W:0] x;
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            if (rstn[g]) begin
                if (iv[g] && ir[g]) begin
                    x      = (RES_W+1)'(s_in[g]) + ((RES_W+1)'(c_in[g]) << 1);
                    e.inst = 2'(g);
                    e.exp  = x;
                    sb.push_back(e);
                    acc_edge[g] = cyc + 1;
                    acc_seen[g] = 1'b1;
                end
                if (ov[g] && !ov_prev[g]) begin
                    check($sformatf("latency[%0d]", g), 32'(cyc - acc_edge[g]), 32'(lat_of(g)));
                end
                if (ov[g] && ordy[g]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("sb_empty[%0d]", g), 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("sb_inst[%0d]", g), 32'(g), 32'(e.inst));
                        check($sformatf("sb_result[%0d]", g), 32'(res[g]), 32'(e.exp[RES_W-1:0]));
                        check($sformatf("sb_ovf[%0d]", g), 32'(ovf[g]), 32'(e.exp[RES_W]));
                    end
                end
            end
            ov_prev[g] = ov[g];
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ordy) begin
            for (int g = 1; g < NCFG; g++) ordy[g] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input int g, input logic [WIDTH+2:0] s, input logic [WIDTH+2:0] c);
        int t = 0;
        s_in[g]     = s;
        c_in[g]     = c;
        iv[g]       = 1'b1;
        acc_seen[g] = 1'b0;
        while (!acc_seen[g] && t < 200) begin
            step();
            t++;
        end
        if (!acc_seen[g]) check($sformatf("accept_timeout[%0d]", g), 32'd0, 32'd1);
        iv[g] = 1'b0;
    endtask

    task automatic wait_ov(input int g);
        int t = 0;
        while (!ov[g] && t < 100) begin
            step();
            t++;
        end
        if (!ov[g]) check($sformatf("valid_timeout[%0d]", g), 32'd0, 32'd1);
    endtask

    // Directed CHUNK=4 scenarios followed by the randomized sweep on the other instances.
    initial begin
        logic [WIDTH+2:0] rs, rc;
        int t;
        n_vec = 0; n_err = 0; cyc = 0;
        rstn = '0; iv = '0; ordy = '1; rand_ordy = 1'b0;
        ov_prev = '0; acc_seen = '0;
        for (int g = 0; g < NCFG; g++) begin
            s_in[g] = '0; c_in[g] = '0; acc_edge[g] = 0;
        end
        repeat (2) step();
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("rst_in_ready[%0d]", g), 32'(ir[g]), 32'd1);
            check($sformatf("rst_out_valid[%0d]", g), 32'(ov[g]), 32'd0);
            check($sformatf("rst_busy[%0d]", g), 32'(busy[g]), 32'd0);
            check($sformatf("rst_result[%0d]", g), 32'(res[g]), 32'd0);
            check($sformatf("rst_ovf[%0d]", g), 32'(ovf[g]), 32'd0);
        end
        rstn = '1;
        step();

        send(0, 11'h155, 11'h2AA);
        check("t1_busy", 32'(busy[0]), 32'd1);
        check("t1_in_ready", 32'(ir[0]), 32'd0);
        wait_ov(0);
        check("t1_result", 32'(res[0]), 32'h6A9);
        check("t1_ovf", 32'(ovf[0]), 32'd0);
        step();
        check("t1_valid_drop", 32'(ov[0]), 32'd0);
        check("t1_idle_ready", 32'(ir[0]), 32'd1);

        send(0, 11'h7FF, 11'h7FF);
        wait_ov(0);
        check("t2_result", 32'(res[0]), 32'h7FD);
        check("t2_ovf", 32'(ovf[0]), 32'd1);
        step();

        ordy[0] = 1'b0;
        send(0, 11'h123, 11'h045);
        wait_ov(0);
        s_in[0] = 11'h0F0;
        c_in[0] = 11'h10F;
        iv[0]   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(ov[0]), 32'd1);
            check("bp_result", 32'(res[0]), 32'h1AD);
            check("bp_ovf", 32'(ovf[0]), 32'd0);
            check("bp_in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        step();
        check("bp_release_valid", 32'(ov[0]), 32'd0);
        check("bp_release_ready", 32'(ir[0]), 32'd1);
        step();
        iv[0] = 1'b0;
        check("bp_second_busy", 32'(busy[0]), 32'd1);
        wait_ov(0);
        check("bp_second_result", 32'(res[0]), 32'h30E);
        step();

        send(0, 11'h7FF, 11'h000);
        wait_ov(0);
        check("ripple1_result", 32'(res[0]), 32'h7FF);
        check("ripple1_ovf", 32'(ovf[0]), 32'd0);
        step();
        send(0, 11'h001, 11'h7FF);
        wait_ov(0);
        check("ripple2_result", 32'(res[0]), 32'hFFF);
        check("ripple2_ovf", 32'(ovf[0]), 32'd0);
        step();

        send(0, 11'h3C3, 11'h1A5);
        step();
        check("mid_busy", 32'(busy[0]), 32'd1);
        rstn[0] = 1'b0;
        step();
        sb.delete();
        check("mid_rst_valid", 32'(ov[0]), 32'd0);
        check("mid_rst_result", 32'(res[0]), 32'd0);
        check("mid_rst_ovf", 32'(ovf[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_ready", 32'(ir[0]), 32'd1);
        rstn[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_no_valid", 32'(ov[0]), 32'd0);
        end
        send(0, 11'h2B4, 11'h311);
        wait_ov(0);
        check("mid_after_result", 32'(res[0]), 32'h8D6);
        step();

        rand_ordy = 1'b1;
        for (int g = 1; g < NCFG; g++) begin
            for (int n = 0; n < NRAND; n++) begin
                rs = (n == 0) ? 11'h7FF : (n == 1) ? 11'h000 : 11'($urandom);
                rc = (n == 0) ? 11'h7FF : (n == 1) ? 11'h000 : 11'($urandom);
                send(g, rs, rc);
            end
            t = 0;
            while (sb.size() != 0 && t < 2000) begin
                step();
                t++;
            end
            check($sformatf("drain[%0d]", g), 32'(sb.size()), 32'd0);
        end
        rand_ordy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csa_resolve_adder.md
Name: csa_resolve_adder

Overview:
- Carry-propagate resolution stage directly downstream of the carry-save adder array in the radix-16 Booth multiplier.
- Accepts one redundant (sum, carry) vector pair and resolves it into a single binary result.
- Resolution is iterative: CHUNK bits per clock through a registered ripple carry, trading latency for adder area.
- Uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 8, multiplicand width; the input vectors are WIDTH+3 bits.
- CHUNK, 4, bits resolved per cycle; legal range 1 to WIDTH+4.
- Derived (localparam, not overridable): RES_W = WIDTH+4; NCHUNK = ceil(RES_W/CHUNK).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sum_in/carry_in hold a valid pair.
- in_ready  output  1  block can accept a pair.
- sum_in  input  WIDTH+3  CSA sum vector; bit i has weight 2^i.
- carry_in  input  WIDTH+3  CSA carry vector; bit i has weight 2^(i+1).
- out_valid  output  1  result_out/ovf_out are valid.
- out_ready  input  1  consumer accepts the result.
- result_out  output  RES_W  (sum + 2*carry) mod 2^RES_W.
- ovf_out  output  1  carry out of bit RES_W-1 of the final addition.
- busy_out  output  1  high while in BUSY state.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset values (rst_n low at a rising edge):
  - state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; busy_out=0.
  - result_out=0; ovf_out=0; chunk index=0; carry register=0.
- Reset mid-operation: the in-flight operation is discarded and no out_valid is produced for it.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture A={1'b0,sum_in} and B={carry_in,1'b0} (both RES_W bits).
  - Same edge: clear the carry register, set idx=0, go to BUSY.
- BUSY:
  - in_ready=0, busy_out=1.
  - Each edge: add bits [idx*CHUNK +: CHUNK] of A, B and the carry register.
  - Write the sum into the same slice of the result register and store the chunk carry-out.
  - idx increments each edge.
  - Last chunk: width RES_W-(NCHUNK-1)*CHUNK, which may be narrower than CHUNK; bits above RES_W-1 are never written.
  - On the edge processing idx=NCHUNK-1: the final carry goes to ovf_out, out_valid goes to 1, state goes to DONE.
- DONE:
  - out_valid=1; result_out and ovf_out are held stable while out_ready=0 (backpressure of unlimited length).
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE.
  - result_out and ovf_out keep their last value until the next capture overwrites them slice by slice.
- Latency: out_valid is high NCHUNK edges after the accepting edge.
- Throughput: one result per NCHUNK+2 cycles minimum (accept, NCHUNK resolve, one DONE cycle with out_ready=1).
- in_ready is 0 in BUSY and DONE; in_valid is ignored there and no pair is captured.
- Operand capture means sum_in/carry_in may change freely after the accepting edge.
- result_out is intermediate (partially updated) while busy_out=1; consumers use it only when out_valid=1.
- CHUNK >= RES_W: NCHUNK=1, single-cycle resolve, still goes IDLE -> BUSY -> DONE.
- CHUNK=1: NCHUNK=RES_W, pure bit-serial.

Test Plan:
- WIDTH=8, CHUNK=4 (RES_W=12, NCHUNK=3): sum_in=0x155, carry_in=0x2AA, in_valid pulse, out_ready=1 -> out_valid high exactly 3 edges after accept; result_out=0x6A9, ovf_out=0.
- Same config, overflow: sum_in=0x7FF, carry_in=0x7FF -> result_out=0x7FD, ovf_out=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid, result_out and ovf_out stable, in_ready=0, a second in_valid is not accepted; out_ready=1 -> IDLE next edge, then the second pair is accepted.
- Chunk ripple: sum_in=0x7FF, carry_in=0x000, then sum_in=0x001, carry_in=0x7FF -> results 0x7FF/ovf 0 and 0xFFF/ovf 0, confirming the carry crosses every chunk boundary.
- Reset mid-operation: assert rst_n=0 at BUSY idx=1 -> next edge in IDLE, out_valid=0, result_out=0, ovf_out=0; a new pair afterwards resolves correctly.
- Parameter sweep WIDTH=8 with CHUNK in {1,5,12}: 1000 random pairs vs reference (sum+2*carry) mod 4096 -> all match; latencies are 12, 3 and 1 edges respectively.
